// File: rtl/counter_sequencer.sv
// counter_sequencer
//
// Queues count jobs in a small FIFO and hands them one at a time to a
// downstream counter. Each job is launched with a one-cycle start pulse.
// The job then finishes when the counter reports its last value, or it
// is abandoned after TIMEOUT wait cycles.
//
// Parameters
//   DEPTH    job FIFO depth in entries (power of two, 2..16)
//   TIMEOUT  maximum WAIT cycles per job (1..255)
//
// Ports
//   clk      rising-edge clock for all state
//   reset    synchronous active-high reset
//   i_valid  job request presented
//   i_num    requested count length of the presented job
//   o_ready  a job can be accepted this cycle (FIFO not full)
//   i_cnt    current value from the downstream counter
//   o_run    one-cycle start pulse to the downstream counter
//   o_num    count length of the active job
//   o_busy   a job is launched and not yet finished
//   o_done   one-cycle pulse on successful completion
//   o_err    one-cycle pulse on a rejected (zero-length) job or a timeout
//   o_jobs   saturating count of completed jobs
module counter_sequencer #(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 32
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       i_valid,
  input  logic [3:0] i_num,
  output logic       o_ready,
  input  logic [3:0] i_cnt,
  output logic       o_run,
  output logic [3:0] o_num,
  output logic       o_busy,
  output logic       o_done,
  output logic       o_err,
  output logic [7:0] o_jobs
);

  // Pointer width; DEPTH is a power of two, so pointers wrap naturally.
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  // Occupancy must be able to represent DEPTH itself.
  localparam int CW = $clog2(DEPTH + 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LAUNCH = 2'd1,
    S_WAIT   = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  state_t state_reg, state_next;

  // Job storage and FIFO bookkeeping
  logic [3:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr_reg;
  logic [AW-1:0] rd_ptr_reg;
  logic [CW-1:0] count_reg;

  // Job control
  logic [7:0] wait_cnt_reg;
  logic [7:0] jobs_reg;
  logic [3:0] num_reg;
  logic       err_reg;

  // Decoded conditions
  logic full;
  logic empty;
  logic accept;
  logic push;
  logic reject;
  logic complete;
  logic timeout;
  logic pop;
  logic launch;

  // ------------------------------------------------------------------
  // Datapath conditions
  // ------------------------------------------------------------------
  always_comb begin
    full     = (count_reg == CW'(DEPTH));
    empty    = (count_reg == '0);
    // Readiness depends only on the current occupancy, so a pop in the
    // same cycle never lets a push through while full.
    accept   = i_valid && !full;
    push     = accept && (i_num != 4'd0);
    reject   = accept && (i_num == 4'd0);
    // Last value of an N-length count is N-1, compared modulo 16.
    complete = (state_reg == S_WAIT) && (i_cnt == (num_reg - 4'd1));
    // The counter shows how many WAIT cycles have already elapsed, so the
    // TIMEOUT-th WAIT cycle is the one where it equals TIMEOUT-1.
    // Completion on that same cycle wins.
    timeout  = (state_reg == S_WAIT) && !complete &&
               (wait_cnt_reg == 8'(TIMEOUT - 1));
    launch   = (state_reg == S_IDLE) && !empty;
    // The head entry stays in the FIFO while its job runs and is only
    // removed once the job finishes either way.
    pop      = (state_reg == S_DONE) || timeout;
  end

  // ------------------------------------------------------------------
  // FSM: state register
  // ------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= S_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // ------------------------------------------------------------------
  // FSM: next-state logic
  // ------------------------------------------------------------------
  always_comb begin
    state_next = state_reg;
    unique case (state_reg)
      S_IDLE: begin
        if (!empty) begin
          state_next = S_LAUNCH;
        end
      end
      S_LAUNCH: begin
        state_next = S_WAIT;
      end
      S_WAIT: begin
        if (complete) begin
          state_next = S_DONE;
        end else if (timeout) begin
          state_next = S_IDLE;
        end
      end
      S_DONE: begin
        state_next = S_IDLE;
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  // ------------------------------------------------------------------
  // FSM: outputs
  // ------------------------------------------------------------------
  always_comb begin
    o_run   = (state_reg == S_LAUNCH);
    o_busy  = (state_reg != S_IDLE);
    o_done  = (state_reg == S_DONE);
    o_ready = !full;
    o_err   = err_reg;
    o_num   = num_reg;
    o_jobs  = jobs_reg;
  end

  // ------------------------------------------------------------------
  // Job storage. Entries need no reset; occupancy alone says what is valid.
  // ------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_reg] <= i_num;
    end
  end

  // ------------------------------------------------------------------
  // FIFO pointers and occupancy
  // ------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + AW'(1);
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + AW'(1);
      end
      unique case ({push, pop})
        2'b10:   count_reg <= count_reg + CW'(1);
        2'b01:   count_reg <= count_reg - CW'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

  // ------------------------------------------------------------------
  // Active job length, wait counter, error pulse and completion count
  // ------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      num_reg      <= 4'd0;
      wait_cnt_reg <= 8'd0;
      err_reg      <= 1'b0;
      jobs_reg     <= 8'd0;
    end else begin
      // o_num is captured once per job and held until the next launch.
      if (launch) begin
        num_reg      <= mem[rd_ptr_reg];
        wait_cnt_reg <= 8'd0;
      end else if (state_reg == S_WAIT) begin
        wait_cnt_reg <= wait_cnt_reg + 8'd1;
      end

      // A rejection and a timeout in the same cycle merge into one pulse.
      err_reg <= reject || timeout;

      if ((state_reg == S_DONE) && (jobs_reg != 8'hFF)) begin
        jobs_reg <= jobs_reg + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_counter_sequencer.sv
// Directed testbench for counter_sequencer (DEPTH=4, TIMEOUT=32).
module tb_counter_sequencer;

  logic       clk;
  logic       reset;
  logic       i_valid;
  logic [3:0] i_num;
  logic       o_ready;
  logic [3:0] i_cnt;
  logic       o_run;
  logic [3:0] o_num;
  logic       o_busy;
  logic       o_done;
  logic       o_err;
  logic [7:0] o_jobs;

  int total = 0;
  int bad   = 0;

  counter_sequencer #(.DEPTH(4), .TIMEOUT(32)) dut (
    .clk     (clk),
    .reset   (reset),
    .i_valid (i_valid),
    .i_num   (i_num),
    .o_ready (o_ready),
    .i_cnt   (i_cnt),
    .o_run   (o_run),
    .o_num   (o_num),
    .o_busy  (o_busy),
    .o_done  (o_done),
    .o_err   (o_err),
    .o_jobs  (o_jobs)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock; inputs are driven and outputs sampled 1 time unit
  // after the rising edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
    $display("check %-18s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Wait (bounded) for the next launch, check its length, answer with the
  // matching last count value and expect completion two cycles later.
  task automatic run_job(input logic [3:0] num, input string tag);
    int n;
    n = 0;
    while (o_run !== 1'b1 && n < 60) begin
      cyc();
      n++;
    end
    chk({tag, "_run"}, 32'(o_run), 32'd1);
    chk({tag, "_num"}, 32'(o_num), 32'(num));
    i_cnt = num - 4'd1;
    cyc();
    chk({tag, "_pulse"}, 32'(o_run), 32'd0);
    cyc();
    chk({tag, "_done"}, 32'(o_done), 32'd1);
    i_cnt = 4'hF;
  endtask

  initial begin
    int n;
    int pulses;

    reset   = 1'b1;
    i_valid = 1'b0;
    i_num   = 4'd0;
    i_cnt   = 4'd0;
    cyc();
    cyc();

    // Reset values
    chk("rst_ready", 32'(o_ready), 32'd1);
    chk("rst_run",   32'(o_run),   32'd0);
    chk("rst_busy",  32'(o_busy),  32'd0);
    chk("rst_done",  32'(o_done),  32'd0);
    chk("rst_err",   32'(o_err),   32'd0);
    chk("rst_jobs",  32'(o_jobs),  32'd0);
    chk("rst_num",   32'(o_num),   32'd0);
    reset = 1'b0;
    cyc();

    // Single job of length 5, counter runs 0..4 after the start pulse
    i_valid = 1'b1;
    i_num   = 4'd5;
    cyc();
    i_valid = 1'b0;
    chk("j5_idle_busy", 32'(o_busy), 32'd0);
    cyc();
    chk("j5_run",  32'(o_run),  32'd1);
    chk("j5_num",  32'(o_num),  32'd5);
    chk("j5_busy", 32'(o_busy), 32'd1);
    cyc();
    for (int k = 0; k < 5; k++) begin
      i_cnt = 4'(k);
      chk($sformatf("j5_w%0d_run", k),  32'(o_run),  32'd0);
      chk($sformatf("j5_w%0d_done", k), 32'(o_done), 32'd0);
      cyc();
    end
    chk("j5_done",     32'(o_done), 32'd1);
    chk("j5_num_hold", 32'(o_num),  32'd5);
    i_cnt = 4'hF;
    cyc();
    chk("j5_done_end", 32'(o_done), 32'd0);
    chk("j5_jobs",     32'(o_jobs), 32'd1);
    chk("j5_idle",     32'(o_busy), 32'd0);

    // Zero-length job is rejected
    i_valid = 1'b1;
    i_num   = 4'd0;
    cyc();
    i_valid = 1'b0;
    chk("zero_err",  32'(o_err),  32'd1);
    chk("zero_busy", 32'(o_busy), 32'd0);
    cyc();
    chk("zero_err_end", 32'(o_err),  32'd0);
    chk("zero_no_run",  32'(o_run),  32'd0);
    chk("zero_no_busy", 32'(o_busy), 32'd0);
    cyc();
    chk("zero_empty", 32'(o_busy), 32'd0);

    // Timeout: job of length 3 that never sees its last count
    i_valid = 1'b1;
    i_num   = 4'd3;
    cyc();
    i_valid = 1'b0;
    cyc();
    chk("to_run", 32'(o_run), 32'd1);
    chk("to_num", 32'(o_num), 32'd3);
    n = 0;
    while (n < 60) begin
      cyc();
      if (o_err === 1'b1) break;
      n++;
    end
    chk("to_wait_cycles", 32'(n),      32'd32);
    chk("to_err",         32'(o_err),  32'd1);
    chk("to_idle",        32'(o_busy), 32'd0);
    chk("to_no_done",     32'(o_done), 32'd0);
    chk("to_jobs",        32'(o_jobs), 32'd1);
    cyc();
    chk("to_err_end", 32'(o_err),  32'd0);
    chk("to_popped",  32'(o_busy), 32'd0);
    cyc();
    chk("to_no_relaunch", 32'(o_run), 32'd0);

    // Fill the FIFO: five back-to-back requests, the fifth is held off
    i_valid = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      i_num = 4'(k);
      chk($sformatf("full_rdy%0d", k), 32'(o_ready), 32'd1);
      cyc();
    end
    chk("full_ready0", 32'(o_ready), 32'd0);
    i_num = 4'd5;
    for (int k = 0; k < 3; k++) begin
      cyc();
      chk($sformatf("full_hold%0d", k), 32'(o_ready), 32'd0);
    end
    i_valid = 1'b0;
    chk("full_head_num", 32'(o_num),  32'd1);
    chk("full_busy",     32'(o_busy), 32'd1);
    i_cnt = 4'd0;
    n = 0;
    while (o_done !== 1'b1 && n < 60) begin
      cyc();
      n++;
    end
    chk("full_j1_done", 32'(o_done), 32'd1);
    i_cnt = 4'hF;
    run_job(4'd2, "full_j2");
    run_job(4'd3, "full_j3");
    run_job(4'd4, "full_j4");
    cyc();
    chk("full_jobs", 32'(o_jobs), 32'd5);
    cyc();
    cyc();
    chk("full_drained_busy",  32'(o_busy),  32'd0);
    chk("full_drained_ready", 32'(o_ready), 32'd1);

    // Ordering: jobs 2, 7, 1
    i_valid = 1'b1;
    i_num   = 4'd2;
    cyc();
    i_num = 4'd7;
    cyc();
    chk("ord_j1_run", 32'(o_run), 32'd1);
    chk("ord_j1_num", 32'(o_num), 32'd2);
    i_num = 4'd1;
    i_cnt = 4'd1;
    cyc();
    i_valid = 1'b0;
    chk("ord_j1_pulse", 32'(o_run), 32'd0);
    cyc();
    chk("ord_j1_done", 32'(o_done), 32'd1);
    i_cnt = 4'hF;
    run_job(4'd7, "ord_j2");
    run_job(4'd1, "ord_j3");
    cyc();
    chk("ord_jobs", 32'(o_jobs), 32'd8);

    // Saturation: stream length-1 jobs that complete immediately
    i_cnt   = 4'd0;
    i_valid = 1'b1;
    i_num   = 4'd1;
    repeat (1300) cyc();
    i_valid = 1'b0;
    repeat (40) cyc();
    chk("sat_jobs",  32'(o_jobs),  32'd255);
    chk("sat_busy",  32'(o_busy),  32'd0);
    chk("sat_ready", 32'(o_ready), 32'd1);

    // Reset during WAIT with two more jobs queued
    i_cnt   = 4'hF;
    i_valid = 1'b1;
    i_num   = 4'd3;
    cyc();
    i_num = 4'd4;
    cyc();
    chk("mid_launch", 32'(o_run), 32'd1);
    i_num = 4'd5;
    cyc();
    i_valid = 1'b0;
    cyc();
    chk("mid_wait_busy", 32'(o_busy), 32'd1);
    chk("mid_wait_num",  32'(o_num),  32'd3);
    reset = 1'b1;
    cyc();
    chk("mid_rst_busy",  32'(o_busy),  32'd0);
    chk("mid_rst_run",   32'(o_run),   32'd0);
    chk("mid_rst_done",  32'(o_done),  32'd0);
    chk("mid_rst_err",   32'(o_err),   32'd0);
    chk("mid_rst_jobs",  32'(o_jobs),  32'd0);
    chk("mid_rst_num",   32'(o_num),   32'd0);
    chk("mid_rst_ready", 32'(o_ready), 32'd1);
    reset = 1'b0;
    pulses = 0;
    for (int k = 0; k < 8; k++) begin
      cyc();
      if (o_run === 1'b1 || o_done === 1'b1 || o_err === 1'b1 || o_busy === 1'b1) pulses++;
    end
    chk("mid_post_quiet", 32'(pulses), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Absolute time limit so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
